// File: rtl/ddr3_device_responder_if.sv
// DDR3 pin bundle between a memory controller (master) and the device-side responder (slave).
interface ddr3_device_responder_if #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16
);
    logic                             reset_n;
    logic                             ck_en;
    logic                             cs_n;
    logic                             ras_n;
    logic                             cas_n;
    logic                             we_n;
    logic [ADDRESS_BITWIDTH-1:0]      address;
    logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address;
    logic [DQ_BITWIDTH-1:0]           dq_in;
    logic                             ldm;
    logic                             udm;
    logic [DQ_BITWIDTH-1:0]           dq_out;
    logic                             dq_oe;
    logic                             dqs_out;
    logic                             dqs_oe;

    modport master (
        output reset_n, ck_en, cs_n, ras_n, cas_n, we_n, address, bank_address, dq_in, ldm, udm,
        input  dq_out, dq_oe, dqs_out, dqs_oe
    );
    modport slave (
        input  reset_n, ck_en, cs_n, ras_n, cas_n, we_n, address, bank_address, dq_in, ldm, udm,
        output dq_out, dq_oe, dqs_out, dqs_oe
    );
endinterface

// File: rtl/ddr3_device_responder.sv
// DDR3 device-side responder: decodes commands, tracks open banks, stores write bursts, returns read bursts.
// Optional DDR3_RESPONDER_AUTO_PRECHARGE_EN: RD/WR with A10=1 close their bank after the last beat.
module ddr3_device_responder #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int COL_BITS              = 5,
    parameter int READ_LATENCY          = 5,
    parameter int WRITE_LATENCY         = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    ddr3_device_responder_if.slave        ddr,
    output logic                          ready,
    output logic                          cmd_error,
    output logic [7:0]                    err_count
);
    localparam int NBANK = 1 << BANK_ADDRESS_BITWIDTH;
    localparam int WIDX  = BANK_ADDRESS_BITWIDTH + COL_BITS;
    // Edge offsets counted from the accepting edge (cnt = 1 on the first edge after it)
    localparam logic [5:0] RD_PRE   = 6'(READ_LATENCY - 2);
    localparam logic [5:0] RD_FIRST = 6'(READ_LATENCY - 1);
    localparam logic [5:0] RD_LAST  = 6'(READ_LATENCY + 6);
    localparam logic [5:0] WR_FIRST = 6'(WRITE_LATENCY);
    localparam logic [5:0] WR_LAST  = 6'(WRITE_LATENCY + 7);

    typedef enum logic {S_POWERUP, S_READY} state_t;
    state_t state, state_nxt;

    logic [NBANK-1:0]                 bank_open, bank_nxt;
    logic [DQ_BITWIDTH-1:0]           mem [1<<WIDX];
    logic [3:0][ADDRESS_BITWIDTH-1:0] mr;
    logic                             pend, pend_rd;
    logic [5:0]                       cnt, pend_last, beat_off;
    logic [BANK_ADDRESS_BITWIDTH-1:0] pend_ba;
    logic [COL_BITS-1:0]              pend_col;
    logic [2:0]                       cmd, beat, beat_col;
    logic [WIDX-1:0]                  beat_idx;
    logic cmd_valid, err_now, accept, accept_rd, mrs_now;
    logic burst_end, rd_pre_now, rd_beat_now, wr_beat_now;
`ifdef DDR3_RESPONDER_AUTO_PRECHARGE_EN
    logic pend_ap;
`endif

    // Mode registers are retained for completeness; latencies stay fixed
    logic unused_mr;
    assign unused_mr = ^mr;

    assign ready     = (state == S_READY);
    assign cmd       = {ddr.ras_n, ddr.cas_n, ddr.we_n};
    assign cmd_valid = (state == S_READY) && ddr.ck_en && !ddr.cs_n;

    assign pend_last   = pend_rd ? RD_LAST : WR_LAST;
    assign burst_end   = pend && (cnt == pend_last);
    assign rd_pre_now  = pend && pend_rd && (cnt == RD_PRE);
    assign rd_beat_now = pend && pend_rd && (cnt >= RD_FIRST) && (cnt <= RD_LAST);
    assign wr_beat_now = pend && !pend_rd && (cnt >= WR_FIRST) && (cnt <= WR_LAST);
    assign beat_off    = pend_rd ? (cnt - RD_FIRST) : (cnt - WR_FIRST);
    assign beat        = beat_off[2:0];
    assign beat_col    = pend_col[2:0] + beat;
    assign beat_idx    = {pend_ba, pend_col[COL_BITS-1:3], beat_col};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_POWERUP;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ddr.reset_n)                             state_nxt = S_POWERUP;
        else if (state == S_POWERUP && ddr.ck_en)     state_nxt = S_READY;
    end

    always_comb begin
        bank_nxt  = bank_open;
        err_now   = 1'b0;
        accept    = 1'b0;
        accept_rd = 1'b0;
        mrs_now   = 1'b0;
        if (!ddr.reset_n) begin
            bank_nxt = '0;
        end else begin
`ifdef DDR3_RESPONDER_AUTO_PRECHARGE_EN
            if (burst_end && pend_ap) bank_nxt[pend_ba] = 1'b0;
`endif
            if (cmd_valid) begin
                case (cmd)
                    3'b011: if (bank_open[ddr.bank_address]) err_now = 1'b1;
                            else bank_nxt[ddr.bank_address] = 1'b1;
                    3'b101, 3'b100: begin
                        if (!bank_open[ddr.bank_address] || pend) err_now = 1'b1;
                        else begin
                            accept    = 1'b1;
                            accept_rd = cmd[0];
                        end
                    end
                    3'b010: if (ddr.address[10]) bank_nxt = '0;
                            else bank_nxt[ddr.bank_address] = 1'b0;
                    3'b001: if (|bank_open) err_now = 1'b1;
                    3'b000: mrs_now = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_open   <= '0;
            mr          <= '0;
            pend        <= 1'b0;
            pend_rd     <= 1'b0;
            cnt         <= '0;
            pend_ba     <= '0;
            pend_col    <= '0;
            cmd_error   <= 1'b0;
            err_count   <= '0;
            ddr.dq_out  <= '0;
            ddr.dq_oe   <= 1'b0;
            ddr.dqs_out <= 1'b0;
            ddr.dqs_oe  <= 1'b0;
`ifdef DDR3_RESPONDER_AUTO_PRECHARGE_EN
            pend_ap     <= 1'b0;
`endif
        end else begin
            bank_open <= bank_nxt;
            cmd_error <= err_now;
            if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (mrs_now) mr[ddr.bank_address[1:0]] <= ddr.address;
            if (!ddr.reset_n) begin
                pend <= 1'b0;
            end else if (accept) begin
                pend     <= 1'b1;
                pend_rd  <= accept_rd;
                cnt      <= 6'd1;
                pend_ba  <= ddr.bank_address;
                pend_col <= ddr.address[COL_BITS-1:0];
`ifdef DDR3_RESPONDER_AUTO_PRECHARGE_EN
                pend_ap  <= ddr.address[10];
`endif
            end else if (burst_end) begin
                pend <= 1'b0;
            end else if (pend) begin
                cnt <= cnt + 6'd1;
            end
            ddr.dq_oe   <= ddr.reset_n && rd_beat_now;
            ddr.dqs_oe  <= ddr.reset_n && (rd_beat_now || rd_pre_now);
            ddr.dqs_out <= ddr.reset_n && rd_beat_now && !beat[0];
            ddr.dq_out  <= (ddr.reset_n && rd_beat_now) ? mem[beat_idx] : '0;
        end
    end

    // Storage has no reset; byte lanes are masked independently
    always_ff @(posedge clk) begin
        if (ddr.reset_n && wr_beat_now) begin
            if (!ddr.ldm) mem[beat_idx][7:0]             <= ddr.dq_in[7:0];
            if (!ddr.udm) mem[beat_idx][DQ_BITWIDTH-1:8] <= ddr.dq_in[DQ_BITWIDTH-1:8];
        end
    end
endmodule
